verdict_stream_packer: RTL and testbench

// Receive-side counterpart to the monitor's input event driver. Samples the monitor's output

---
 rtl/verdict_stream_packer.sv | 142 ++++++++++++++
 tb/tb_verdict_stream_packer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/verdict_stream_packer.sv
// rtl/verdict_stream_packer.sv - captures active monitor outputs with a timestamp, buffers and serialises them
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   en              global enable: advances the timestamp and allows capture
//   out_flat        monitor output values, output i at [i*DATA_W +: DATA_W]
//   out_aktv        per-output active flags
//   m_data/m_valid/m_ready/m_last  serialised word stream (header then active values)
//   fifo_level      records currently buffered (not counting the one being sent)
//   overflow        sticky record-drop flag
//   drop_cnt        saturating count of dropped records
module verdict_stream_packer #(
  parameter int NUM_OUT = 5,
  parameter int DATA_W  = 64,
  parameter int TS_W    = 32,
  parameter int DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_OUT*DATA_W-1:0]    out_flat,
  input  logic [NUM_OUT-1:0]           out_aktv,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow,
  output logic [15:0]                  drop_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int REC_W = TS_W + NUM_OUT + NUM_OUT * DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [REC_W-1:0]          mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [TS_W-1:0]           ts;
  logic [1:0]                state;

  // Working register: the record currently being serialised
  logic [TS_W-1:0]           w_ts;
  logic [NUM_OUT-1:0]        w_mask;
  logic [NUM_OUT*DATA_W-1:0] w_vals;
  logic [IDX_W-1:0]          idx;

  logic wr_req, full, empty, do_wr, drop, hs, do_pop, has_next;
  logic [IDX_W-1:0] first_idx, next_idx;

  assign wr_req = en && (|out_aktv);
  assign full   = (fifo_level == LVL_W'(DEPTH));
  assign empty  = (fifo_level == '0);
  // Fullness is taken before any same-edge pop, so a write to a full FIFO is lost
  assign do_wr  = wr_req && !full;
  assign drop   = wr_req && full;
  assign hs     = m_valid && m_ready;

  // Lowest set mask bit, and lowest set bit strictly above the current index
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (w_mask[i]) first_idx = IDX_W'(i);
      if (w_mask[i] && (i > int'(idx))) begin
        has_next = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  // Pop when idle, or on the final word's handshake so records chain with no bubble
  assign do_pop = !empty && ((state == S_IDLE) || ((state == S_DATA) && hs && !has_next));

  always_comb begin
    m_data = '0;
    if (state == S_HDR) begin
      m_data[DATA_W-1 -: TS_W]  = w_ts;
      m_data[NUM_OUT-1:0]       = w_mask;
    end else if (state == S_DATA) begin
      m_data = w_vals[int'(idx)*DATA_W +: DATA_W];
    end
  end

  assign m_valid = (state != S_IDLE);
  assign m_last  = (state == S_DATA) && !has_next;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {ts, out_aktv, out_flat};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      state      <= S_IDLE;
      idx        <= '0;
      w_ts       <= '0;
      w_mask     <= '0;
      w_vals     <= '0;
    end else begin
      if (en) ts <= ts + 1'b1;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {w_ts, w_mask, w_vals} <= mem[rd_ptr];
      end
      case ({do_wr, do_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
      case (state)
        S_IDLE: if (do_pop) state <= S_HDR;
        S_HDR: if (hs) begin
          state <= S_DATA;
          idx   <= first_idx;
        end
        S_DATA: if (hs) begin
          if (has_next)    idx   <= next_idx;
          else if (do_pop) state <= S_HDR;
          else             state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_verdict_stream_packer.sv
// tb/tb_verdict_stream_packer.sv - self-checking bench for verdict_stream_packer
module tb_verdict_stream_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [319:0] out_flat = '0;
  logic [4:0]   out_aktv = '0;
  logic [63:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic [3:0]   fifo_level;
  logic         overflow;
  logic [15:0]  drop_cnt;

  verdict_stream_packer dut (
    .clk(clk), .rst(rst), .en(en), .out_flat(out_flat), .out_aktv(out_aktv),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of captured records and the word list of the record in flight
  typedef struct { logic [31:0] ts; logic [4:0] mask; logic [319:0] vals; } rec_t;
  typedef struct { logic [63:0] d; logic l; } word_t;
  rec_t  rec_q[$];
  word_t cur[$];
  logic [31:0] m_ts = '0;
  logic        m_ovf = 1'b0;
  int          m_drop = 0;

  task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    rec_q.delete();
    cur.delete();
    m_ts = '0;
    m_ovf = 1'b0;
    m_drop = 0;
  endtask

  task automatic model_edge(input logic e, input logic [4:0] a, input logic r, input logic [319:0] v);
    bit full_pre, busy, hs, lastw;
    rec_t rc;
    word_t w;
    full_pre = (rec_q.size() == 8);
    busy = (cur.size() > 0);
    hs = busy && r;
    lastw = hs && cur[0].l;
    if (hs) void'(cur.pop_front());
    if ((!busy || lastw) && rec_q.size() > 0) begin
      rc = rec_q.pop_front();
      w.d = {rc.ts, 27'b0, rc.mask};
      w.l = 1'b0;
      cur.push_back(w);
      for (int i = 0; i < 5; i++) begin
        if (rc.mask[i]) begin
          w.d = rc.vals[i*64 +: 64];
          w.l = ((rc.mask >> (i + 1)) == 5'b0);
          cur.push_back(w);
        end
      end
    end
    if (e && a != 5'b0) begin
      if (full_pre) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end else begin
        rc.ts = m_ts; rc.mask = a; rc.vals = v;
        rec_q.push_back(rc);
      end
    end
    if (e) m_ts = m_ts + 1;
  endtask

  task automatic check_model();
    logic ok;
    logic ev, el;
    logic [63:0] ed;
    ev = (cur.size() > 0);
    ed = ev ? cur[0].d : 64'd0;
    el = ev ? cur[0].l : 1'b0;
    ok = (m_valid == ev) && (!ev || (m_data == ed && m_last == el)) &&
         (int'(fifo_level) == rec_q.size()) && (overflow == m_ovf) && (int'(drop_cnt) == m_drop);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL model t=%0t: valid=%b data=%h last=%b lvl=%0d ovf=%b drop=%0d expected valid=%b data=%h last=%b lvl=%0d ovf=%b drop=%0d",
               $time, m_valid, m_data, m_last, fifo_level, overflow, drop_cnt,
               ev, ed, el, rec_q.size(), m_ovf, m_drop);
    end
  endtask

  task automatic step(input logic e, input logic [4:0] a, input logic r, input logic [319:0] v);
    en = e; out_aktv = a; m_ready = r; out_flat = v;
    @(posedge clk);
    model_edge(e, a, r, v);
    @(negedge clk);
    check_model();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((cur.size() > 0 || rec_q.size() > 0) && n < 200) begin
      step(1'b0, 5'b0, 1'b1, '0);
      n++;
    end
    check("drain_bound", n < 200, 64'(n), 64'd200);
  endtask

  function automatic logic [319:0] rand_vals();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    logic e; logic [4:0] a; logic r;
    logic ev; logic el; logic [63:0] ed; logic [3:0] elv;
  } vec_t;
  vec_t tbl[5];

  initial begin
    logic [319:0] v1;
    logic [63:0]  hold_d;
    logic         hold_l;
    logic [31:0]  t0;
    int           words;

    v1 = '0;
    v1[63:0]    = 64'd7;
    v1[191:128] = 64'hFFFF_FFFF_FFFF_FFFD;
    tbl[0] = '{1'b1, 5'b00101, 1'b1, 1'b0, 1'b0, 64'd0, 4'd1};
    tbl[1] = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b0, 64'h0000_000A_0000_0005, 4'd0};
    tbl[2] = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b0, 64'd7, 4'd0};
    tbl[3] = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 4'd0};
    tbl[4] = '{1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 64'd0, 4'd0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", m_valid == 1'b0, 64'(m_valid), 64'd0);
    check("rst_last",  m_last == 1'b0, 64'(m_last), 64'd0);
    check("rst_data",  m_data == 64'd0, m_data, 64'd0);
    check("rst_level", fifo_level == 4'd0, 64'(fifo_level), 64'd0);
    check("rst_ovf_drop", overflow == 1'b0 && drop_cnt == 16'd0, {overflow, drop_cnt}, 64'd0);
    rst = 1'b0;

    // 1) single record with ts=10
    repeat (10) step(1'b1, 5'b0, 1'b1, v1);
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].e, tbl[i].a, tbl[i].r, v1);
      check($sformatf("tbl%0d", i),
            m_valid == tbl[i].ev && m_last == tbl[i].el && m_data == tbl[i].ed && fifo_level == tbl[i].elv,
            {m_valid, m_last, m_data[57:0], fifo_level}, {tbl[i].ev, tbl[i].el, tbl[i].ed[57:0], tbl[i].elv});
    end

    // 2) back-to-back full-mask records at ts 20 and 21
    while (m_ts != 32'd20) step(1'b1, 5'b0, 1'b1, '0);
    step(1'b1, 5'b11111, 1'b1, rand_vals());
    step(1'b1, 5'b11111, 1'b1, rand_vals());
    words = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) check("b2b_hdr0_ts", m_data[63:32] == 32'd20, 64'(m_data[63:32]), 64'd20);
      if (i == 6) check("b2b_hdr1_ts", m_data[63:32] == 32'd21, 64'(m_data[63:32]), 64'd21);
      if (m_valid) words++;
      step(1'b0, 5'b0, 1'b1, '0);
    end
    check("b2b_no_gap", words == 12, 64'(words), 64'd12);
    check("b2b_idle_after", m_valid == 1'b0, 64'(m_valid), 64'd0);

    // 3) backpressure during header and on the second data word
    step(1'b1, 5'b10110, 1'b0, rand_vals());
    step(1'b0, 5'b0, 1'b0, '0);
    hold_d = m_data; hold_l = m_last;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'b0, 1'b0, '0);
      check("bp_hdr_stable", m_valid && m_data == hold_d && m_last == hold_l, m_data, hold_d);
    end
    step(1'b0, 5'b0, 1'b1, '0);
    step(1'b0, 5'b0, 1'b1, '0);
    hold_d = m_data; hold_l = m_last;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'b0, 1'b0, '0);
      check("bp_data_stable", m_valid && m_data == hold_d && m_last == hold_l, m_data, hold_d);
    end
    drain();

    // 4) overflow: one record held in the serialiser, then 10 captures with sink stalled
    step(1'b1, 5'b00001, 1'b0, rand_vals());
    step(1'b0, 5'b0, 1'b0, '0);
    t0 = m_ts;
    for (int i = 0; i < 10; i++) step(1'b1, 5'($urandom_range(1, 31)), 1'b0, rand_vals());
    check("ovf_level", fifo_level == 4'd8, 64'(fifo_level), 64'd8);
    check("ovf_flag",  overflow == 1'b1, 64'(overflow), 64'd1);
    check("ovf_drop",  drop_cnt == 16'd2, 64'(drop_cnt), 64'd2);
    step(1'b0, 5'b0, 1'b1, '0);
    step(1'b0, 5'b0, 1'b1, '0);
    for (int k = 0; k < 8; k++) begin
      check("ovf_order_ts", m_valid && m_data[63:32] == t0 + 32'(k), 64'(m_data[63:32]), 64'(t0 + 32'(k)));
      while (m_valid && !m_last) step(1'b0, 5'b0, 1'b1, '0);
      step(1'b0, 5'b0, 1'b1, '0);
    end
    drain();

    // 5) en=0 blocks capture and freezes ts while a buffered record drains
    step(1'b1, 5'b01001, 1'b1, rand_vals());
    t0 = m_ts;
    for (int i = 0; i < 5; i++) step(1'b0, 5'b00001, 1'b1, rand_vals());
    check("en0_level", fifo_level == 4'd0 && m_valid == 1'b0, 64'(fifo_level), 64'd0);
    step(1'b1, 5'b00001, 1'b1, rand_vals());
    step(1'b0, 5'b0, 1'b1, '0);
    check("en0_ts_frozen", m_valid && m_data[63:32] == t0, 64'(m_data[63:32]), 64'(t0));
    drain();

    // 6) reset mid-DATA
    step(1'b1, 5'b00011, 1'b1, rand_vals());
    step(1'b0, 5'b0, 1'b1, '0);
    step(1'b0, 5'b0, 1'b1, '0);
    check("pre_rst_in_data", m_valid && !m_last, 64'(m_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", m_valid == 1'b0, 64'(m_valid), 64'd0);
    check("rst_async_state", fifo_level == 4'd0 && drop_cnt == 16'd0 && !overflow, {fifo_level, drop_cnt}, 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 5'b00001, 1'b1, v1);
    step(1'b0, 5'b0, 1'b1, '0);
    check("post_rst_hdr", m_valid && m_data == 64'h0000_0000_0000_0001, m_data, 64'h1);
    drain();

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? 5'b0 : 5'($urandom),
           ($urandom_range(0, 3) != 0), rand_vals());
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
